kms_event_sched: RTL and testbench

KMS_EVENT_SCHED -- requirements
Module: kms_event_sched

---
 rtl/kms_pkg.sv | 19 +
 rtl/kms_fifo.sv | 49 ++++
 rtl/kms_event_sched.sv | 144 ++++++++++++++
 tb/tb_kms_event_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kms_pkg.sv
// Shared encodings for the keyboard/mouse/OSD event scheduler: event types and FSM states.
package kms_pkg;

  typedef enum logic [1:0] {
    KMS_MOUSE_X = 2'd0,
    KMS_MOUSE_Y = 2'd1,
    KMS_KEY     = 2'd2,
    KMS_OSD     = 2'd3
  } kms_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } kms_state_e;

  localparam int KMS_LEVEL_W = 7;

endpackage

// File: rtl/kms_fifo.sv
// First-word fall-through FIFO; head is valid the cycle after a push into an empty FIFO.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kms_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kms_event_sched.sv
// Routes SPI keyboard/mouse/OSD events: mouse accumulators, keyboard FIFO with ack/timeout/holdoff FSM.
// Optional OSD pass-through enabled by defining KMS_OSD_EN; otherwise OSD outputs tie to 0.
module kms_event_sched #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLDOFF     = 16,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       kms_strobe,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic [2:0] mouse_buttons_in,
  input  logic       kbd_ack,
  input  logic       clr_flags,
  output logic [7:0] mouse_x,
  output logic [7:0] mouse_y,
  output logic [2:0] mouse_btn,
  output logic       kbd_valid,
  output logic [7:0] kbd_code,
  output logic       osd_valid,
  output logic [7:0] osd_code,
  output logic       kbd_overflow,
  output logic       kbd_timeout,
  output logic [6:0] fifo_level
);
  import kms_pkg::*;

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int HW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam kms_state_e AFTER_POP = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;

  // Assertion is asynchronous; release takes effect on the first clk_sys edge.
  logic rst_sync;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync <= 1'b0;
    else          rst_sync <= 1'b1;
  end

  kms_type_e  ev_type;
  kms_state_e state;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic       push;
  logic       pop;
  logic       ack_hit;
  logic       to_hit;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic [FAW:0] fifo_lvl;

  assign ev_type = kms_type_e'(kms_type);
  assign push    = kms_strobe && (ev_type == KMS_KEY);
  assign ack_hit = (state == ST_PRESENT) && kbd_ack;
  assign to_hit  = (ACK_TIMEOUT != 0) && (state == ST_PRESENT) && !kbd_ack &&
                   (tcnt == TW'(ACK_TIMEOUT - 1));
  assign pop     = ack_hit || to_hit;

  kms_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk_sys),
    .rst_n     (rst_sync),
    .push      (push),
    .push_data (kms_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_lvl)
  );

  assign fifo_level = KMS_LEVEL_W'(fifo_lvl);

  always_ff @(posedge clk_sys or negedge rst_sync) begin
    if (!rst_sync) begin
      state       <= ST_IDLE;
      kbd_valid   <= 1'b0;
      kbd_code    <= '0;
      kbd_timeout <= 1'b0;
      tcnt        <= '0;
      hcnt        <= '0;
    end else begin
      kbd_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            kbd_code  <= fifo_head;
            kbd_valid <= 1'b1;
            tcnt      <= '0;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (pop) begin
            kbd_valid   <= 1'b0;
            kbd_timeout <= to_hit;
            hcnt        <= '0;
            state       <= AFTER_POP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_HOLDOFF: begin
          if (hcnt == HW'(HOLDOFF - 1)) state <= ST_IDLE;
          else                          hcnt  <= hcnt + HW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // 8-bit add is the sign-extended add modulo 256.
  always_ff @(posedge clk_sys or negedge rst_sync) begin
    if (!rst_sync) begin
      mouse_x      <= '0;
      mouse_y      <= '0;
      mouse_btn    <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      mouse_btn <= mouse_buttons_in;
      if (kms_strobe && ev_type == KMS_MOUSE_X) mouse_x <= mouse_x + kms_data;
      if (kms_strobe && ev_type == KMS_MOUSE_Y) mouse_y <= mouse_y + kms_data;
      if (push && fifo_full && !pop) kbd_overflow <= 1'b1;
      else if (clr_flags)            kbd_overflow <= 1'b0;
    end
  end

`ifdef KMS_OSD_EN
  always_ff @(posedge clk_sys or negedge rst_sync) begin
    if (!rst_sync) begin
      osd_valid <= 1'b0;
      osd_code  <= '0;
    end else begin
      osd_valid <= kms_strobe && (ev_type == KMS_OSD);
      if (kms_strobe && ev_type == KMS_OSD) osd_code <= kms_data;
    end
  end
`else
  assign osd_valid = 1'b0;
  assign osd_code  = '0;
`endif

endmodule

// File: tb/tb_kms_event_sched.sv
// Self-checking bench for kms_event_sched: directed vectors plus randomized run against a queue model.
module tb_kms_event_sched;

  localparam int DEPTH = 8;
  localparam int HO    = 16;
  localparam int TO    = 100;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic       kms_strobe = 1'b0;
  logic [1:0] kms_type = 2'd0;
  logic [7:0] kms_data = 8'd0;
  logic [2:0] mouse_buttons_in = 3'd0;
  logic       kbd_ack = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] mouse_x, mouse_y, kbd_code, osd_code;
  logic [2:0] mouse_btn;
  logic       kbd_valid, osd_valid, kbd_overflow, kbd_timeout;
  logic [6:0] fifo_level;

  kms_event_sched #(.FIFO_DEPTH(DEPTH), .HOLDOFF(HO), .ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kms_strobe(kms_strobe), .kms_type(kms_type),
    .kms_data(kms_data), .mouse_buttons_in(mouse_buttons_in), .kbd_ack(kbd_ack),
    .clr_flags(clr_flags), .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
    .kbd_valid(kbd_valid), .kbd_code(kbd_code), .osd_valid(osd_valid), .osd_code(osd_code),
    .kbd_overflow(kbd_overflow), .kbd_timeout(kbd_timeout), .fifo_level(fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic idle_in();
    kms_strobe = 1'b0;
    kbd_ack    = 1'b0;
    clr_flags  = 1'b0;
  endtask

  task automatic ev(input logic [1:0] t, input logic [7:0] d);
    kms_strobe = 1'b1;
    kms_type   = t;
    kms_data   = d;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (kbd_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  // Codes are only meaningful while their valid is high.
  function automatic logic [63:0] pack(input logic [7:0] x, input logic [7:0] y, input logic [2:0] b,
                                       input logic kv, input logic [7:0] kc, input logic ov,
                                       input logic [7:0] oc, input logic fl, input logic t,
                                       input logic [6:0] lv);
    return {18'd0, x, y, b, kv, (kv ? kc : 8'h00), ov, (ov ? oc : 8'h00), fl, t, lv};
  endfunction

  function automatic logic [63:0] dut_outs();
    return pack(mouse_x, mouse_y, mouse_btn, kbd_valid, kbd_code, osd_valid, osd_code,
                kbd_overflow, kbd_timeout, fifo_level);
  endfunction

  // Reference model: a queue of pending keys plus presentation age and remaining holdoff.
  logic [7:0] m_x, m_y, m_kc, m_osdc;
  logic [2:0] m_btn;
  logic       m_kv, m_to, m_ovf, m_osdv;
  logic [7:0] q[$];
  int         age, hold_left;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_kc = 0; m_osdc = 0; m_btn = 0;
    m_kv = 0; m_to = 0; m_ovf = 0; m_osdv = 0;
    q.delete();
    age = 0; hold_left = 0;
  endtask

  task automatic model_step();
    bit pop, tout, push, ovf_evt;
    int sz0;
    pop = 0; tout = 0;
    sz0 = q.size();
    if (m_kv) begin
      if (kbd_ack) pop = 1;
      else if (TO > 0 && age + 1 == TO) begin pop = 1; tout = 1; end
    end
    push    = kms_strobe && kms_type == 2'd2;
    ovf_evt = push && sz0 == DEPTH && !pop;
    if (m_kv) begin
      if (pop) begin m_kv = 0; hold_left = HO; end
      else age++;
    end else if (hold_left > 0) begin
      hold_left--;
    end else if (sz0 > 0) begin
      m_kv = 1; m_kc = q[0]; age = 0;
    end
    if (pop) void'(q.pop_front());
    if (push && !ovf_evt) q.push_back(kms_data);
    m_to  = tout;
    m_ovf = ovf_evt ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    if (kms_strobe && kms_type == 2'd0) m_x = m_x + kms_data;
    if (kms_strobe && kms_type == 2'd1) m_y = m_y + kms_data;
    m_btn = mouse_buttons_in;
`ifdef KMS_OSD_EN
    m_osdv = kms_strobe && kms_type == 2'd3;
    if (m_osdv) m_osdc = kms_data;
`endif
  endtask

  typedef struct {
    logic [1:0] typ;
    logic [7:0] dat;
    logic [2:0] btn;
    logic [7:0] ex;
    logic [7:0] ey;
  } mvec_t;

  mvec_t      mt[7];
  logic [7:0] drain_exp[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, m;
    mt[0] = '{2'd0, 8'h7F, 3'd1, 8'h7F, 8'h00};
    mt[1] = '{2'd0, 8'h05, 3'd2, 8'h84, 8'h00};
    mt[2] = '{2'd1, 8'hFF, 3'd4, 8'h84, 8'hFF};
    mt[3] = '{2'd0, 8'h80, 3'd7, 8'h04, 8'hFF};
    mt[4] = '{2'd1, 8'h02, 3'd0, 8'h04, 8'h01};
    mt[5] = '{2'd1, 8'h81, 3'd5, 8'h04, 8'h82};
    mt[6] = '{2'd0, 8'hFC, 3'd3, 8'h00, 8'h82};
    drain_exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h6F};

    // Reset state
    #2 reset_n = 1'b0;
    step(); step();
    chk("reset_outs", dut_outs(), 64'd0);
    chk("reset_codes", {kbd_code, osd_code}, 16'd0);

    // Event on the first edge after release is ignored; second edge accepted (table row 0)
    reset_n = 1'b1;
    ev(2'd0, 8'h33);
    step(); idle_in();
    chk("sync_first_edge_ignored", mouse_x, 8'h00);

    for (int i = 0; i < 7; i++) begin
      ev(mt[i].typ, mt[i].dat);
      mouse_buttons_in = mt[i].btn;
      step(); idle_in();
      chk($sformatf("mouse_x[%0d]", i), mouse_x, mt[i].ex);
      chk($sformatf("mouse_y[%0d]", i), mouse_y, mt[i].ey);
      chk($sformatf("mouse_btn[%0d]", i), mouse_btn, mt[i].btn);
      chk($sformatf("mouse_nolevel[%0d]", i), fifo_level, 7'd0);
    end

    // Handshake and holdoff
    ev(2'd2, 8'h45); step(); idle_in();
    chk("hs_n1_valid", kbd_valid, 1'b0);
    chk("hs_n1_level", fifo_level, 7'd1);
    step();
    chk("hs_n2_valid", kbd_valid, 1'b1);
    chk("hs_n2_code", kbd_code, 8'h45);
    ev(2'd2, 8'h46); step(); idle_in();
    repeat (6) step();
    chk("hs_stable", {kbd_valid, kbd_code}, {1'b1, 8'h45});
    chk("hs_level2", fifo_level, 7'd2);
    kbd_ack = 1'b1; step(); kbd_ack = 1'b0;
    chk("hs_ack_drop", kbd_valid, 1'b0);
    chk("hs_ack_pop", fifo_level, 7'd1);
    kbd_ack = 1'b1; repeat (5) step(); kbd_ack = 1'b0;
    chk("hs_ack_ignored", {kbd_valid, fifo_level}, {1'b0, 7'd1});
    wait_valid(100, n);
    chk("hs_holdoff_len", 5 + n, HO + 1);
    chk("hs_next_code", kbd_code, 8'h46);
    kbd_ack = 1'b1; step(); kbd_ack = 1'b0;
    chk("hs_empty", {kbd_valid, fifo_level}, {1'b0, 7'd0});
    repeat (HO + 2) step();

    // Overflow
    for (int i = 0; i < 9; i++) begin
      ev(2'd2, 8'(8'h60 + i));
      step();
    end
    idle_in();
    chk("ovf_level", fifo_level, 7'd8);
    chk("ovf_flag", kbd_overflow, 1'b1);
    chk("ovf_head", {kbd_valid, kbd_code}, {1'b1, 8'h60});
    ev(2'd2, 8'h6E); clr_flags = 1'b1; step(); idle_in();
    chk("ovf_wins_clr", kbd_overflow, 1'b1);
    clr_flags = 1'b1; step(); idle_in();
    chk("ovf_cleared", kbd_overflow, 1'b0);
    ev(2'd2, 8'h6F); kbd_ack = 1'b1; step(); idle_in();
    chk("full_push_pop_level", fifo_level, 7'd8);
    chk("full_push_pop_noovf", kbd_overflow, 1'b0);
    for (int k = 0; k < 8; k++) begin
      wait_valid(60, n);
      chk($sformatf("ovf_drain[%0d]", k), {kbd_valid, kbd_code}, {1'b1, drain_exp[k]});
      kbd_ack = 1'b1; step(); kbd_ack = 1'b0;
    end
    wait_valid(60, n);
    chk("ovf_9th_absent", {kbd_valid, fifo_level}, {1'b0, 7'd0});

    // Timeout
    ev(2'd2, 8'h70); step(); ev(2'd2, 8'h71); step(); idle_in();
    wait_valid(10, n);
    chk("to_first", {kbd_valid, kbd_code}, {1'b1, 8'h70});
    m = 0;
    while (kbd_timeout !== 1'b1 && m < 200) begin
      step();
      m++;
    end
    chk("to_delay", m, TO);
    chk("to_valid_low", kbd_valid, 1'b0);
    step();
    chk("to_one_cycle", kbd_timeout, 1'b0);
    wait_valid(60, n);
    chk("to_holdoff", n, HO);
    chk("to_next", {kbd_code, fifo_level}, {8'h71, 7'd1});
    kbd_ack = 1'b1; step(); kbd_ack = 1'b0;
    repeat (HO + 2) step();

    // Reset mid-PRESENT with queued keys
    mouse_buttons_in = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ev(2'd2, 8'(8'h21 + i));
      step();
    end
    idle_in(); step();
    chk("rst_pre", {kbd_valid, kbd_code, fifo_level}, {1'b1, 8'h21, 7'd4});
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_outs", dut_outs(), 64'd0);
    chk("rst_async_code", kbd_code, 8'h00);
    step();
    reset_n = 1'b1;
    step();
    ev(2'd2, 8'h12); step(); idle_in();
    chk("rst_post_level", fifo_level, 7'd1);
    step();
    chk("rst_post_key", {kbd_valid, kbd_code}, {1'b1, 8'h12});
    kbd_ack = 1'b1; step(); kbd_ack = 1'b0;
    repeat (HO + 2) step();

    // OSD
    ev(2'd3, 8'h5A); step(); idle_in();
`ifdef KMS_OSD_EN
    chk("osd_pulse", {osd_valid, osd_code}, {1'b1, 8'h5A});
`else
    chk("osd_off", {osd_valid, osd_code}, {1'b0, 8'h00});
`endif
    chk("osd_no_fifo", fifo_level, 7'd0);
    step();
    chk("osd_one_cycle", osd_valid, 1'b0);

    // Randomized run against the model
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      int mode;
      chk($sformatf("rand_c%0d", c), dut_outs(),
          pack(m_x, m_y, m_btn, m_kv, m_kc, m_osdv, m_osdc, m_ovf, m_to, 7'(q.size())));
      mode = (c / 500) % 3;
      kms_strobe       = ($urandom_range(1, 0) == 1);
      kms_type         = 2'($urandom_range(3, 0));
      kms_data         = 8'($urandom);
      mouse_buttons_in = 3'($urandom);
      clr_flags        = ($urandom_range(39, 0) == 0);
      case (mode)
        0:       kbd_ack = ($urandom_range(3, 0) == 0);
        1:       kbd_ack = 1'b0;
        default: kbd_ack = ($urandom_range(1, 0) == 0);
      endcase
      model_step();
      step();
    end
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
